// File: rtl/inst_sram_responder.sv
// Responder end of the fetch-stage inst_sram interface: a synchronous single-port
// 64-bit SRAM with byte write enables, optional read wait states and a pipeline
// stall request. A read returns the addressed doubleword and the 32-bit
// instruction selected by addr[2].
//
// Optional feature macro: SRAM_ERR_EN
//   defined   - out-of-range accesses are flagged on inst_sram_err; out-of-range
//               reads return zero and out-of-range writes are dropped
//   undefined - no range check, the word index wraps, inst_sram_err stays 0
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_sram_en      request strobe
//   inst_sram_we      byte write enables, 0 = read
//   inst_sram_addr    byte address
//   inst_sram_wdata   write data, lane i = wdata[8i+7:8i]
//   inst_sram_rdata   last read doubleword
//   inst_sram_inst    last read instruction (addr[2] selects the upper half)
//   inst_sram_rvalid  one-cycle pulse when rdata/inst update
//   stallreq          high while a read sits in wait states
//   inst_sram_err     one-cycle out-of-range pulse
module inst_sram_responder #(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_sram_en,
    input  logic [7:0]  inst_sram_we,
    input  logic [63:0] inst_sram_addr,
    input  logic [63:0] inst_sram_wdata,
    output logic [63:0] inst_sram_rdata,
    output logic [31:0] inst_sram_inst,
    output logic        inst_sram_rvalid,
    output logic        stallreq,
    output logic        inst_sram_err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    logic [63:0] mem [DEPTH];

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q;
    logic                   addr2_q;
    logic                   oor_q;

    logic [63:0]            offset_c;
    logic [DEPTH_LOG2-1:0]  req_idx_c;
    logic                   req_oor_c;

    logic                   latch_c;
    logic                   wr_fire_c;
    logic                   rd_fire_c;
    logic [DEPTH_LOG2-1:0]  rd_idx_c;
    logic                   rd_addr2_c;
    logic                   rd_oor_c;
    logic [63:0]            rd_data_c;
    logic                   stall_d;
    logic                   err_d;

    // Word index relative to the base address; addr[1:0] only feeds the subtract
    assign offset_c  = inst_sram_addr - BASE_ADDR;
    assign req_idx_c = DEPTH_LOG2'(offset_c >> 3);

`ifdef SRAM_ERR_EN
    // Below base (subtract borrowed) or beyond the array
    assign req_oor_c = (inst_sram_addr < BASE_ADDR) ||
                       ((offset_c >> (DEPTH_LOG2 + 3)) != 64'd0);
`else
    assign req_oor_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, request decode and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_c    = 1'b0;
        wr_fire_c  = 1'b0;
        rd_fire_c  = 1'b0;
        rd_idx_c   = idx_q;
        rd_addr2_c = addr2_q;
        rd_oor_c   = oor_q;
        stall_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_sram_en) begin
                    if (inst_sram_we != 8'd0) begin
                        wr_fire_c = !req_oor_c;
                        err_d     = req_oor_c;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero-wait read samples the array at the accept edge
                        rd_fire_c  = 1'b1;
                        rd_idx_c   = req_idx_c;
                        rd_addr2_c = inst_sram_addr[2];
                        rd_oor_c   = req_oor_c;
                    end else begin
                        latch_c = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                        stall_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Requests are ignored here; the last wait cycle reads the array
                if (cnt_q == CNT_W'(1)) begin
                    rd_fire_c = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rd_fire_c && rd_oor_c) begin
            err_d = 1'b1;
        end
    end

    assign rd_data_c = rd_oor_c ? 64'd0 : mem[rd_idx_c];

    // Array write port with byte lanes; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            for (int i = 0; i < 8; i++) begin
                if (inst_sram_we[i]) begin
                    mem[req_idx_c][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Latched read request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q            <= '0;
            addr2_q          <= 1'b0;
            oor_q            <= 1'b0;
            inst_sram_rdata  <= '0;
            inst_sram_inst   <= '0;
            inst_sram_rvalid <= 1'b0;
            stallreq         <= 1'b0;
            inst_sram_err    <= 1'b0;
        end else begin
            inst_sram_rvalid <= rd_fire_c;
            stallreq         <= stall_d;
            inst_sram_err    <= err_d;
            if (latch_c) begin
                idx_q   <= req_idx_c;
                addr2_q <= inst_sram_addr[2];
                oor_q   <= req_oor_c;
            end
            if (rd_fire_c) begin
                inst_sram_rdata <= rd_data_c;
                inst_sram_inst  <= rd_addr2_c ? rd_data_c[63:32] : rd_data_c[31:0];
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench: zero-wait instance driven from a vector table, three-wait
// instance exercised by hand-written wait-state, ignore-in-wait and reset sequences.
module tb_inst_sram_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait instance
    logic        e0;
    logic [7:0]  we0;
    logic [63:0] a0, wd0, rd0;
    logic [31:0] in0;
    logic        rv0, st0, er0;

    // Three-wait instance
    logic        e3;
    logic [7:0]  we3;
    logic [63:0] a3, wd3, rd3;
    logic [31:0] in3;
    logic        rv3, st3, er3;

    inst_sram_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .inst_sram_en(e0), .inst_sram_we(we0), .inst_sram_addr(a0), .inst_sram_wdata(wd0),
        .inst_sram_rdata(rd0), .inst_sram_inst(in0), .inst_sram_rvalid(rv0),
        .stallreq(st0), .inst_sram_err(er0)
    );

    inst_sram_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .inst_sram_en(e3), .inst_sram_we(we3), .inst_sram_addr(a3), .inst_sram_wdata(wd3),
        .inst_sram_rdata(rd3), .inst_sram_inst(in3), .inst_sram_rvalid(rv3),
        .stallreq(st3), .inst_sram_err(er3)
    );

    typedef struct {
        logic        en;
        logic [7:0]  we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        rvalid;
        logic [63:0] rdata;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

`ifdef SRAM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    function automatic vec_t mk(logic en, logic [7:0] we, logic [63:0] addr, logic [63:0] wdata,
                                logic rvalid, logic [63:0] rdata, logic [31:0] inst, logic err);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rvalid = rvalid; v.rdata = rdata; v.inst = inst; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for rvalid on the three-wait instance; returns edges taken, 0 on timeout
    task automatic wait_rv3(output int n);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rv3) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;

        e0 = 0; we0 = 0; a0 = 0; wd0 = 0;
        e3 = 0; we3 = 0; a3 = 0; wd3 = 0;

        // Zero-wait table: inputs for one cycle, outputs expected after its edge
        vecs.push_back(mk(1, 8'hFF, 64'h8000_0000, 64'h1122334455667788, 0, 64'h0, 32'h0, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_0004, 64'h0, 1, 64'h1122334455667788, 32'h11223344, 0));
        vecs.push_back(mk(1, 8'h01, 64'h8000_0000, 64'h00000000000000AA, 0, 64'h1122334455667788, 32'h11223344, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_0000, 64'h0, 1, 64'h11223344556677AA, 32'h556677AA, 0));
        vecs.push_back(mk(1, 8'hFF, 64'h8000_0008, 64'hCAFEBABEDEADBEEF, 0, 64'h11223344556677AA, 32'h556677AA, 0));
        vecs.push_back(mk(1, 8'hF0, 64'h8000_0008, 64'h0123456789ABCDEF, 0, 64'h11223344556677AA, 32'h556677AA, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_0000, 64'h0, 1, 64'h11223344556677AA, 32'h556677AA, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_0004, 64'h0, 1, 64'h11223344556677AA, 32'h11223344, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_0008, 64'h0, 1, 64'h01234567DEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 8'h00, 64'h8000_0000, 64'h0, 0, 64'h01234567DEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_000F, 64'h0, 1, 64'h01234567DEADBEEF, 32'h01234567, 0));
        vecs.push_back(mk(1, 8'hFF, 64'h8000_7FF8, 64'h5555AAAA5A5A5A5A, 0, 64'h01234567DEADBEEF, 32'h01234567, 0));
        vecs.push_back(mk(1, 8'h00, 64'h8000_7FF8, 64'h0, 1, 64'h5555AAAA5A5A5A5A, 32'h5A5A5A5A, 0));
        if (ERR_ON) begin
            vecs.push_back(mk(1, 8'h00, 64'h7FFF_FFFC, 64'h0, 1, 64'h0, 32'h0, 1));
            vecs.push_back(mk(1, 8'hFF, 64'h8000_8000, 64'hFFEEDDCCBBAA9988, 0, 64'h0, 32'h0, 1));
            vecs.push_back(mk(1, 8'h00, 64'h8000_0000, 64'h0, 1, 64'h11223344556677AA, 32'h556677AA, 0));
        end else begin
            vecs.push_back(mk(1, 8'h00, 64'h7FFF_FFFC, 64'h0, 1, 64'h5555AAAA5A5A5A5A, 32'h5555AAAA, 0));
            vecs.push_back(mk(1, 8'hFF, 64'h8000_8000, 64'hFFEEDDCCBBAA9988, 0, 64'h5555AAAA5A5A5A5A, 32'h5555AAAA, 0));
            vecs.push_back(mk(1, 8'h00, 64'h8000_0000, 64'h0, 1, 64'hFFEEDDCCBBAA9988, 32'hBBAA9988, 0));
        end

        // Reset values
        #3;
        chk("rst_rdata", rd0, 64'h0);
        chk("rst_inst", 64'(in0), 64'h0);
        chk("rst_rvalid", 64'(rv0), 64'h0);
        chk("rst_stall3", 64'(st3), 64'h0);
        chk("rst_err", 64'(er0), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven zero-wait vectors
        for (int i = 0; i < vecs.size(); i++) begin
            e0 = vecs[i].en; we0 = vecs[i].we; a0 = vecs[i].addr; wd0 = vecs[i].wdata;
            step();
            chk($sformatf("v%0d_rvalid", i), 64'(rv0), 64'(vecs[i].rvalid));
            chk($sformatf("v%0d_rdata", i), rd0, vecs[i].rdata);
            chk($sformatf("v%0d_inst", i), 64'(in0), 64'(vecs[i].inst));
            chk($sformatf("v%0d_err", i), 64'(er0), 64'(vecs[i].err));
            chk($sformatf("v%0d_stall", i), 64'(st0), 64'h0);
        end
        e0 = 0; we0 = 0;

        // Three-wait read: stall window and writes ignored during it
        e3 = 1; we3 = 8'hFF; a3 = 64'h8000_0010; wd3 = 64'h0BADF00D12345678;
        step();
        chk("w3_stall", 64'(st3), 64'h0);
        we3 = 8'h00; a3 = 64'h8000_0014;
        step();
        chk("w3_T_stall", 64'(st3), 64'h1);
        chk("w3_T_rvalid", 64'(rv3), 64'h0);
        we3 = 8'hFF; a3 = 64'h8000_0010; wd3 = 64'h0;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i < 3) begin
                chk($sformatf("w3_T%0d_stall", i), 64'(st3), 64'h1);
                chk($sformatf("w3_T%0d_rvalid", i), 64'(rv3), 64'h0);
            end else begin
                chk("w3_T3_stall", 64'(st3), 64'h0);
                chk("w3_T3_rvalid", 64'(rv3), 64'h1);
                chk("w3_T3_rdata", rd3, 64'h0BADF00D12345678);
                chk("w3_T3_inst", 64'(in3), 64'h0BADF00D);
            end
        end
        e3 = 0; we3 = 0;
        step();
        chk("w3_pulse", 64'(rv3), 64'h0);
        chk("w3_hold", rd3, 64'h0BADF00D12345678);

        // Re-read shows the in-wait write was dropped
        e3 = 1; a3 = 64'h8000_0010;
        step();
        e3 = 0;
        wait_rv3(n);
        chk("w3_latency", 64'(n), 64'd3);
        chk("w3_reread", rd3, 64'h0BADF00D12345678);
        chk("w3_reread_inst", 64'(in3), 64'h12345678);
        chk("w3_reread_err", 64'(er3), 64'h0);

        // Below-base read still takes the wait states
        step();
        e3 = 1; a3 = 64'h7FFF_FFF8;
        step();
        e3 = 0;
        wait_rv3(n);
        chk("w3_oor_latency", 64'(n), 64'd3);
        chk("w3_oor_err", 64'(er3), 64'(ERR_ON));
        step();
        chk("w3_oor_err_pulse", 64'(er3), 64'h0);

        // Reset in the middle of a waited read
        e3 = 1; a3 = 64'h8000_0010;
        step();
        e3 = 0;
        chk("mr_stall", 64'(st3), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_stall0", 64'(st3), 64'h0);
        chk("mr_rvalid0", 64'(rv3), 64'h0);
        chk("mr_rdata0", rd3, 64'h0);
        chk("mr_inst0", 64'(in3), 64'h0);
        chk("mr_rdata_dut0", rd0, 64'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("mr_after%0d_rvalid", i), 64'(rv3), 64'h0);
            chk($sformatf("mr_after%0d_stall", i), 64'(st3), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
